// File: rtl/pipe_flow_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_flow_ctrl
//
// Stall/flush sequencer for a 5-stage MIPS pipeline with exceptions and
// interrupts. Decides each cycle whether the F/D registers advance, whether
// a bubble goes into E, whether every pipeline register is flushed for an
// exception, and where the next PC comes from. It also tracks how long the
// multi-cycle mult/div unit (MDU) stays busy.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset (0 = reset)
//   D_rs/D_rt    register fields of the instruction in D
//   D_rs_use0    D instruction reads rs in D (branch/jr)
//   D_rt_use0    D instruction reads rt in D
//   D_md         D instruction uses the MDU (mult/div/mfhi/mflo/mthi/mtlo)
//   D_eret       D instruction is eret
//   E_load       E instruction is a load
//   E_wa         E destination register
//   E_md_start   E instruction starts the MDU
//   E_md_div     1 = div/divu, 0 = mult/multu (qualified by E_md_start)
//   E_mtc0_epc   E instruction writes EPC
//   M_mtc0_epc   M instruction writes EPC
//   req          CP0 exception/interrupt request for the M instruction
//   F_we         PC register enable
//   D_we         D pipeline register write enable
//   E_clr        clear E register (insert bubble)
//   flush_all    flush request to every pipeline register
//   npc_sel      0 = sequential/branch, 1 = exception entry, 2 = EPC
//   md_busy      MDU busy (includes the start cycle)
// -----------------------------------------------------------------------------
module pipe_flow_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] D_rs,
    input  logic [4:0] D_rt,
    input  logic       D_rs_use0,
    input  logic       D_rt_use0,
    input  logic       D_md,
    input  logic       D_eret,
    input  logic       E_load,
    input  logic [4:0] E_wa,
    input  logic       E_md_start,
    input  logic       E_md_div,
    input  logic       E_mtc0_epc,
    input  logic       M_mtc0_epc,
    input  logic       req,
    output logic       F_we,
    output logic       D_we,
    output logic       E_clr,
    output logic       flush_all,
    output logic [1:0] npc_sel,
    output logic       md_busy
);

    localparam logic [1:0] NPC_SEQ = 2'd0;
    localparam logic [1:0] NPC_EXC = 2'd1;
    localparam logic [1:0] NPC_EPC = 2'd2;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic busy_now;
    logic stall_ld, stall_md, stall_er, stall;

    // MD_BUSY is held exactly while the counter is non-zero, so the state bit
    // doubles as the (cnt != 0) term of md_busy.
    assign busy_now = (state_q == MD_BUSY) | E_md_start;

    assign stall_ld = E_load & (E_wa != 5'd0)
                    & ((D_rs_use0 & (D_rs == E_wa)) | (D_rt_use0 & (D_rt == E_wa)));
    assign stall_md = D_md & busy_now;
    assign stall_er = D_eret & (E_mtc0_epc | M_mtc0_epc);
    assign stall    = stall_ld | stall_md | stall_er;

    // Next-state for the MDU busy counter. An exception aborts any MDU op and
    // refuses a new one; a start is only taken from idle (the D_md stall keeps
    // a second MDU instruction out of E while busy).
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        cnt_d = cnt_q;
        if (req) begin
            cnt_d = '0;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else if (E_md_start) begin
            cnt_d = E_md_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
        end
        state_d = (cnt_d != '0) ? MD_BUSY : RUN;
    end

    // NOTE: sequential state uses non-blocking assignments only; the reset is
    // asynchronous so the counter clears without waiting for a clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            state_q <= RUN;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    // Pipeline control: exception beats stall, stall beats eret redirect.
    // While reset is held every output sits at its idle value.
    always_comb begin
        F_we      = 1'b1;
        D_we      = 1'b1;
        E_clr     = 1'b0;
        flush_all = 1'b0;
        npc_sel   = NPC_SEQ;
        md_busy   = 1'b0;
        if (reset) begin
            md_busy = busy_now;
            if (req) begin
                flush_all = 1'b1;
                npc_sel   = NPC_EXC;
            end else if (stall) begin
                F_we  = 1'b0;
                D_we  = 1'b0;
                E_clr = 1'b1;
            end else if (D_eret) begin
                npc_sel = NPC_EPC;
            end
        end
    end

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_flow_ctrl
//
// Directed bench for pipe_flow_ctrl. A model tracks MDU occupancy as a
// "busy until cycle N" timestamp and derives the expected controls from the
// stall/flush rules; a compare process checks every output on each falling
// edge, and the directed sequences add hand-computed literal checks.
// -----------------------------------------------------------------------------
`timescale 1ns/100ps
module tb_pipe_flow_ctrl;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] D_rs, D_rt, E_wa;
    logic       D_rs_use0, D_rt_use0, D_md, D_eret;
    logic       E_load, E_md_start, E_md_div, E_mtc0_epc, M_mtc0_epc, req;
    logic       F_we, D_we, E_clr, flush_all, md_busy;
    logic [1:0] npc_sel;

    int total = 0;
    int bad   = 0;

    pipe_flow_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .D_rs(D_rs), .D_rt(D_rt), .D_rs_use0(D_rs_use0), .D_rt_use0(D_rt_use0),
        .D_md(D_md), .D_eret(D_eret),
        .E_load(E_load), .E_wa(E_wa), .E_md_start(E_md_start), .E_md_div(E_md_div),
        .E_mtc0_epc(E_mtc0_epc), .M_mtc0_epc(M_mtc0_epc), .req(req),
        .F_we(F_we), .D_we(D_we), .E_clr(E_clr), .flush_all(flush_all),
        .npc_sel(npc_sel), .md_busy(md_busy)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    // cyc counts active clock edges; the MDU is busy in cycle k when
    // k <= busy_end. A start in cycle s keeps it busy through s+LAT.
    longint cyc      = 0;
    longint busy_end = -1;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_end = cyc - 1;
        end else begin
            if (req)
                busy_end = cyc;
            else if (E_md_start && !(cyc <= busy_end))
                busy_end = cyc + (E_md_div ? DIV_LAT : MULT_LAT);
            cyc++;
        end
    end

    logic       x_fwe, x_dwe, x_eclr, x_flush, x_busy;
    logic [1:0] x_npc;

    task automatic model_outputs();
        logic s;
        x_fwe = 1; x_dwe = 1; x_eclr = 0; x_flush = 0; x_npc = 0; x_busy = 0;
        if (reset === 1'b1) begin
            x_busy = (cyc <= busy_end) || E_md_start;
            s = (E_load && E_wa != 0 &&
                 ((D_rs_use0 && D_rs == E_wa) || (D_rt_use0 && D_rt == E_wa)))
              || (D_md && x_busy)
              || (D_eret && (E_mtc0_epc || M_mtc0_epc));
            if (req) begin
                x_flush = 1; x_npc = 1;
            end else if (s) begin
                x_fwe = 0; x_dwe = 0; x_eclr = 1;
            end else begin
                x_npc = D_eret ? 2'd2 : 2'd0;
            end
        end
    endtask

    always @(negedge clk) begin
        model_outputs();
        check("cmp F_we",      32'(F_we),      32'(x_fwe));
        check("cmp D_we",      32'(D_we),      32'(x_dwe));
        check("cmp E_clr",     32'(E_clr),     32'(x_eclr));
        check("cmp flush_all", 32'(flush_all), 32'(x_flush));
        check("cmp npc_sel",   32'(npc_sel),   32'(x_npc));
        check("cmp md_busy",   32'(md_busy),   32'(x_busy));
    end

    // ---------------- stimulus ----------------
    task automatic idle_inputs();
        D_rs = 0; D_rt = 0; E_wa = 0;
        D_rs_use0 = 0; D_rt_use0 = 0; D_md = 0; D_eret = 0;
        E_load = 0; E_md_start = 0; E_md_div = 0;
        E_mtc0_epc = 0; M_mtc0_epc = 0; req = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        #5;
        check("rst F_we",    32'(F_we),    32'd1);
        check("rst D_we",    32'(D_we),    32'd1);
        check("rst E_clr",   32'(E_clr),   32'd0);
        check("rst npc_sel", 32'(npc_sel), 32'd0);
        check("rst md_busy", 32'(md_busy), 32'd0);
        #30 reset = 1'b1;
        step();

        // 2: mult start with an MDU instr waiting in D
        E_md_start = 1; E_md_div = 0; D_md = 1;
        #1;
        check("mult start D_we", 32'(D_we),  32'd0);
        check("mult start E_clr", 32'(E_clr), 32'd1);
        step();
        E_md_start = 0;
        for (int i = 1; i <= MULT_LAT; i++) begin
            check("mult busy D_we", 32'(D_we), 32'd0);
            step();
        end
        check("mult done D_we",    32'(D_we),    32'd1);
        check("mult done md_busy", 32'(md_busy), 32'd0);
        idle_inputs();
        step();

        // 3: div aborted by an exception three cycles after the start
        E_md_start = 1; E_md_div = 1;
        step();
        E_md_start = 0;
        step();
        step();
        req = 1;
        #1;
        check("exc flush_all", 32'(flush_all), 32'd1);
        check("exc npc_sel",   32'(npc_sel),   32'd1);
        check("exc F_we",      32'(F_we),      32'd1);
        step();
        req = 0;
        #1;
        check("after exc md_busy", 32'(md_busy), 32'd0);
        idle_inputs();
        step();

        // 4: load-use hazard, then the same with $zero as destination
        E_load = 1; E_wa = 8; D_rs = 8; D_rs_use0 = 1;
        #1;
        check("ld-use F_we",  32'(F_we),  32'd0);
        check("ld-use E_clr", 32'(E_clr), 32'd1);
        step();
        E_wa = 0; D_rs = 0;
        #1;
        check("ld r0 F_we",  32'(F_we),  32'd1);
        check("ld r0 E_clr", 32'(E_clr), 32'd0);
        idle_inputs();
        step();

        // 5: eret waits for the EPC write to leave E and M
        D_eret = 1; E_mtc0_epc = 1;
        #1;
        check("eret E F_we", 32'(F_we), 32'd0);
        step();
        E_mtc0_epc = 0; M_mtc0_epc = 1;
        #1;
        check("eret M F_we",    32'(F_we),    32'd0);
        check("eret M npc_sel", 32'(npc_sel), 32'd0);
        step();
        M_mtc0_epc = 0;
        #1;
        check("eret go npc_sel", 32'(npc_sel), 32'd2);
        check("eret go F_we",    32'(F_we),    32'd1);
        idle_inputs();
        step();

        // 6: start coinciding with an exception is dropped
        E_md_start = 1; E_md_div = 1; req = 1;
        #1;
        check("start+req flush_all", 32'(flush_all), 32'd1);
        step();
        E_md_start = 0; req = 0;
        #1;
        check("start+req md_busy", 32'(md_busy), 32'd0);
        step();

        // 1: asynchronous reset in the middle of a div (counter at 7)
        E_md_start = 1; E_md_div = 1;
        step();
        E_md_start = 0; D_md = 1;
        step();
        step();
        step();
        check("pre-rst D_we", 32'(D_we), 32'd0);
        #2 reset = 1'b0;
        #1;
        check("async rst md_busy", 32'(md_busy), 32'd0);
        check("async rst D_we",    32'(D_we),    32'd1);
        check("async rst E_clr",   32'(E_clr),   32'd0);
        #1 reset = 1'b1;
        #1;
        check("post-rst md_busy", 32'(md_busy), 32'd0);
        check("post-rst D_we",    32'(D_we),    32'd1);
        idle_inputs();
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
